// File: rtl/spi3w_pkg.sv
// Shared types and width helpers for the 3-wire SPI byte controller.
package spi3w_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    WRITE,
    READ,
    HOLD,
    CS_HIGH
  } state_e;

  localparam int BYTE_W = 8;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_controller_ht16d35a_half_tick.sv
// Half-period timebase: pulses tick every HALF clk cycles, restarted by clr.
module spi_half_tick #(
  parameter int HALF = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (clr || cnt_q == '0) cnt_d = W'(HALF - 1);
    tick = !clr && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= W'(HALF - 1);
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_controller_ht16d35a.sv
// Byte-oriented 3-wire SPI master: write burst, bus turnaround, optional read
// burst, framed by active-low chip selects. SCK idles high.
module spi_controller_ht16d35a
  import spi3w_pkg::*;
#(
  parameter int NUM_SELECTS    = 1,
  parameter int CLK_DIV        = 20,
  parameter int OUT_BYTES      = 5,
  parameter int IN_BYTES       = 4,
  parameter int ALL_DONE_DELAY = 1,
  parameter int LSB_FIRST      = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 sck,
  input  logic                                 dio_i,
  output logic                                 dio_o,
  output logic                                 dio_e,
  output logic [NUM_SELECTS-1:0]               cs,
  output logic                                 busy,
  input  logic                                 activate,
  input  logic [NUM_SELECTS-1:0]               in_cs,
  input  logic [OUT_BYTES-1:0][BYTE_W-1:0]     out_data,
  input  logic [$clog2(OUT_BYTES+1)-1:0]       out_count,
  output logic [IN_BYTES-1:0][BYTE_W-1:0]      in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0]        in_count
);

  localparam int OW = $clog2(OUT_BYTES + 1);
  localparam int IW = $clog2(IN_BYTES + 1);
  localparam int BW = max_i(OW, IW);
  localparam int HW = cnt_w(2 * ALL_DONE_DELAY);

  state_e                          state_q, state_d;
  logic                            sck_q, sck_d;
  logic [NUM_SELECTS-1:0]          cs_q, cs_d;
  logic [OUT_BYTES-1:0][BYTE_W-1:0] obuf_q, obuf_d;
  logic [IN_BYTES-1:0][BYTE_W-1:0] in_data_q, in_data_d;
  logic [BW-1:0]                   out_n_q, out_n_d, in_n_q, in_n_d;
  logic [BW-1:0]                   byte_q, byte_d;
  logic [2:0]                      bit_q, bit_d;
  logic [HW-1:0]                   hold_q, hold_d;

  logic             tick, last_bit;
  logic [2:0]       bsel;
  logic [BYTE_W-1:0] cur_byte;

  spi_half_tick #(.HALF(CLK_DIV / 2)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    obuf_d    = obuf_q;
    in_data_d = in_data_q;
    out_n_d   = out_n_q;
    in_n_d    = in_n_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    hold_d    = hold_q;

    last_bit = (bit_q == 3'd7);
    bsel     = (LSB_FIRST != 0) ? bit_q : ~bit_q;
    cur_byte = '0;
    for (int k = 0; k < OUT_BYTES; k++)
      if (byte_q == BW'(k)) cur_byte = obuf_q[k];

    // Data pad follows the current bit index, which advances on the falling SCK.
    dio_e = (state_q == WRITE);
    dio_o = dio_e & cur_byte[bsel];
    busy  = (state_q != IDLE);

    unique case (state_q)
      IDLE: if (activate) begin
        state_d = CS_SETUP;
        cs_d    = ~in_cs;
        obuf_d  = out_data;
        out_n_d = (out_count > OW'(OUT_BYTES)) ? BW'(OUT_BYTES) : BW'(out_count);
        in_n_d  = (in_count > IW'(IN_BYTES)) ? BW'(IN_BYTES) : BW'(in_count);
      end
      CS_SETUP: if (tick) begin
        byte_d = '0;
        bit_d  = '0;
        hold_d = '0;
        if (out_n_q != '0)     begin state_d = WRITE; sck_d = 1'b0; end
        else if (in_n_q != '0) begin state_d = READ;  sck_d = 1'b0; end
        else                         state_d = HOLD;
      end
      WRITE: if (tick) begin
        if (!sck_q) sck_d = 1'b1;
        else if (last_bit && byte_q == out_n_q - BW'(1)) begin
          byte_d = '0;
          bit_d  = '0;
          hold_d = '0;
          if (in_n_q != '0) begin state_d = READ; sck_d = 1'b0; end
          else                    state_d = HOLD;
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q + 3'd1;
          if (last_bit) byte_d = byte_q + BW'(1);
        end
      end
      READ: if (tick) begin
        if (!sck_q) begin
          sck_d = 1'b1;
          for (int k = 0; k < IN_BYTES; k++)
            if (byte_q == BW'(k)) in_data_d[k][bsel] = dio_i;
        end else if (last_bit && byte_q == in_n_q - BW'(1)) begin
          state_d = HOLD;
          hold_d  = '0;
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q + 3'd1;
          if (last_bit) byte_d = byte_q + BW'(1);
        end
      end
      HOLD: if (tick) begin
        if (hold_q == HW'(2 * ALL_DONE_DELAY - 1)) begin
          state_d = CS_HIGH;
          cs_d    = '1;
        end else hold_d = hold_q + HW'(1);
      end
      CS_HIGH: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sck_q     <= 1'b1;
      cs_q      <= '1;
      obuf_q    <= '0;
      in_data_q <= '0;
      out_n_q   <= '0;
      in_n_q    <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      obuf_q    <= obuf_d;
      in_data_q <= in_data_d;
      out_n_q   <= out_n_d;
      in_n_q    <= in_n_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
    end
  end

  assign sck     = sck_q;
  assign cs      = cs_q;
  assign in_data = in_data_q;

endmodule

// File: tb/tb_spi_controller_ht16d35a.sv
// Scoreboard bench: expected bits/frames queued at stimulus, checked on SCK/CS/busy events.
module tb_spi_controller_ht16d35a;
  localparam int CLK_DIV = 20;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  logic sck, dio_i = 0, dio_o, dio_e, busy, activate = 0;
  logic [0:0] cs, in_cs = 1'b1;
  logic [4:0][7:0] od = '0;
  logic [3:0][7:0] in_data;
  logic [2:0] out_count = 0, in_count = 0;

  spi_controller_ht16d35a dut (
    .clk(clk), .reset(reset), .sck(sck), .dio_i(dio_i), .dio_o(dio_o), .dio_e(dio_e),
    .cs(cs), .busy(busy), .activate(activate), .in_cs(in_cs), .out_data(od),
    .out_count(out_count), .in_data(in_data), .in_count(in_count));

  // MSB-first instance with a fast SCK
  logic m_sck, m_dio_i = 0, m_dio_o, m_dio_e, m_busy, m_activate = 0;
  logic [0:0] m_cs;
  logic [4:0][7:0] m_od = '0;
  logic [3:0][7:0] m_in_data;

  spi_controller_ht16d35a #(.CLK_DIV(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .sck(m_sck), .dio_i(m_dio_i), .dio_o(m_dio_o), .dio_e(m_dio_e),
    .cs(m_cs), .busy(m_busy), .activate(m_activate), .in_cs(1'b1), .out_data(m_od),
    .out_count(3'd1), .in_data(m_in_data), .in_count(3'd1));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit exp_bits[$], rd_bits[$], m_exp[$], m_rd[$];
  int exp_edges[$], exp_w[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mdl_in = 0;

  int cyc = 0, n_edges = 0, last_rise = 0, wb = 0, cs_rise = 0, n_txn = 0, m_edges = 0;
  bit abort = 0;
  logic sck_p = 1, cs_p = 1, busy_p = 0, dio_e_p = 0, m_sck_p = 1;

  always @(negedge clk) begin
    int e;
    cyc++;
    if (!reset && !abort) begin
      if (sck && !sck_p) begin
        chk("cs_at_sck", cs, 0);
        if (n_edges > 0) chk("sck_period", cyc - last_rise, CLK_DIV);
        last_rise = cyc;
        n_edges++;
        if (dio_e) begin
          wb++;
          if (exp_bits.size() == 0) chk("extra_wbit", 1, 0);
          else chk("wbit", dio_o, exp_bits.pop_front());
        end
      end
      if (!sck && sck_p && !dio_e && busy)
        dio_i = (rd_bits.size() != 0) ? rd_bits.pop_front() : 1'b0;
      if (!dio_e && dio_e_p) chk("dio_e_drop", wb, (exp_w.size() != 0) ? exp_w[0] : -1);
      if (cs && !cs_p) begin
        cs_rise = cyc;
        e = (exp_edges.size() != 0) ? exp_edges.pop_front() : -1;
        chk("edges", n_edges, e);
        if (n_edges > 0) chk("hold_len", cyc - last_rise, CLK_DIV / 2 + CLK_DIV);
      end
      if (!busy && busy_p) begin
        chk("busy_tail", cyc - cs_rise, CLK_DIV / 2);
        chk("in_data", in_data, (exp_rd.size() != 0) ? exp_rd.pop_front() : 32'hDEADBEEF);
        if (exp_w.size() != 0) void'(exp_w.pop_front());
        n_txn++;
        n_edges = 0;
        wb = 0;
      end
      if (m_sck && !m_sck_p) begin
        m_edges++;
        if (m_dio_e) begin
          if (m_exp.size() == 0) chk("msb_extra", 1, 0);
          else chk("msb_bit", m_dio_o, m_exp.pop_front());
        end
      end
      if (!m_sck && m_sck_p && !m_dio_e && m_busy)
        m_dio_i = (m_rd.size() != 0) ? m_rd.pop_front() : 1'b0;
    end
    sck_p = sck; cs_p = cs[0]; busy_p = busy; dio_e_p = dio_e; m_sck_p = m_sck;
  end

  task automatic push_exp(input int oc, input int ic, input logic [31:0] rd);
    int o, i;
    o = (oc > 5) ? 5 : oc;
    i = (ic > 4) ? 4 : ic;
    for (int b = 0; b < o; b++)
      for (int k = 0; k < 8; k++) exp_bits.push_back(od[b][k]);
    for (int b = 0; b < i; b++) begin
      for (int k = 0; k < 8; k++) rd_bits.push_back(rd[8*b+k]);
      mdl_in[8*b +: 8] = rd[8*b +: 8];
    end
    exp_edges.push_back(8 * (o + i));
    exp_w.push_back(8 * o);
    exp_rd.push_back(mdl_in);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin @(negedge clk); n++; end
    chk("busy_timeout", busy, 0);
  endtask

  task automatic start(input int oc, input int ic, input logic [31:0] rd);
    out_count = 3'(oc);
    in_count  = 3'(ic);
    push_exp(oc, ic, rd);
    @(negedge clk);
    activate = 1;
    chk("busy_pre", busy, 0);
    @(negedge clk);
    chk("busy_rise", busy, 1);
    activate = 0;
  endtask

  task automatic go(input int oc, input int ic, input logic [31:0] rd);
    start(oc, ic, rd);
    wait_idle(4000);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t0, n;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1); chk("rst_sck", sck, 1); chk("rst_dio_e", dio_e, 0);
    chk("rst_dio_o", dio_o, 0); chk("rst_busy", busy, 0); chk("rst_in_data", in_data, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    od[0] = 8'h40; go(1, 0, 0);
    od = {8'h08, 8'h04, 8'h02, 8'h01, 8'hC0}; go(5, 0, 0);
    od[0] = 8'h42; go(1, 4, 32'h00FF3CA5);
    go(7, 7, 32'h12345678);
    go(0, 0, 0);

    // activate held 3 cycles: one frame only
    od[0] = 8'h40; out_count = 1; in_count = 0;
    push_exp(1, 0, 0);
    t0 = n_txn;
    @(negedge clk); activate = 1;
    repeat (3) @(negedge clk);
    activate = 0;
    wait_idle(4000);
    repeat (5) @(negedge clk);
    chk("one_txn", n_txn - t0, 1);

    // activate held through completion: immediate restart
    od[0] = 8'h3C;
    push_exp(1, 0, 0); push_exp(1, 0, 0);
    t0 = n_txn;
    @(negedge clk); activate = 1;
    @(negedge clk); chk("b2b_busy", busy, 1);
    wait_idle(4000);
    @(negedge clk); chk("restart", busy, 1);
    activate = 0;
    wait_idle(4000);
    repeat (5) @(negedge clk);
    chk("two_txn", n_txn - t0, 2);

    // pulse while busy is ignored
    od[0] = 8'h81;
    t0 = n_txn;
    start(1, 0, 0);
    repeat (40) @(negedge clk);
    activate = 1;
    @(negedge clk);
    activate = 0;
    wait_idle(4000);
    repeat (5) @(negedge clk);
    chk("pulse_ignored", n_txn - t0, 1);

    // reset after 3 write bits
    od[0] = 8'h40; od[1] = 8'h81;
    start(2, 0, 0);
    n = 0;
    while (n_edges < 3 && n < 2000) begin @(negedge clk); n++; end
    chk("edge_timeout", (n_edges >= 3), 1);
    abort = 1; reset = 1;
    @(posedge clk); #1;
    exp_bits.delete(); exp_edges.delete(); exp_w.delete(); exp_rd.delete(); rd_bits.delete();
    n_edges = 0; wb = 0; mdl_in = 0; dio_i = 0;
    @(negedge clk);
    chk("abort_cs", cs, 1); chk("abort_sck", sck, 1);
    chk("abort_dio_e", dio_e, 0); chk("abort_busy", busy, 0);
    reset = 0;
    @(negedge clk); abort = 0;
    od[0] = 8'h40; go(1, 1, 32'h5A);

    // MSB-first: 0x80 out, 0x01 in
    m_od[0] = 8'h80;
    for (int k = 7; k >= 0; k--) m_exp.push_back(m_od[0][k]);
    for (int k = 0; k < 8; k++) m_rd.push_back(k == 7);
    @(negedge clk); m_activate = 1;
    @(negedge clk); chk("m_busy_rise", m_busy, 1);
    m_activate = 0;
    n = 0;
    while (m_busy && n < 1000) begin @(negedge clk); n++; end
    chk("m_busy_timeout", m_busy, 0);
    chk("m_in_data", m_in_data, 32'h01);
    chk("m_edges", m_edges, 16);
    chk("m_bits_left", m_exp.size(), 0);

    chk("bits_left", exp_bits.size(), 0);
    chk("frames_left", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_controller_ht16d35a.md
Name: spi_controller_ht16d35a

Overview:
- Byte-oriented controller for a 3-wire (shared bidirectional data) SPI bus, as used by HT16D35A / TM1638-class LED drivers.
- A command FSM loads up to OUT_BYTES bytes and calls it with a level `activate`/`busy` handshake.
- The block shifts the bytes out on the data line, then turns the line around and optionally reads up to IN_BYTES bytes.
- It owns SCK, the data tri-state control and the active-low chip selects. The external bidirectional pad buffer is instantiated outside this block.

Parameters:
- NUM_SELECTS, 1, number of chip-select lines.
- CLK_DIV, 20, clk cycles per SCK period; must be even and ≥2. Half period is CLK_DIV/2.
- OUT_BYTES, 5, capacity of the output byte array.
- IN_BYTES, 4, capacity of the input byte array.
- ALL_DONE_DELAY, 1, number of full SCK periods SCK stays high after the last bit before CS is released.
- LSB_FIRST, 1, 1 = bit 0 of each byte goes first; 0 = bit 7 goes first. Applies to both directions.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sck  out  1  serial clock; idles high.
- dio_i  in  1  data from the pad buffer.
- dio_o  out  1  data to the pad buffer.
- dio_e  out  1  pad output enable; 1 = drive.
- cs  out  NUM_SELECTS  chip selects, active low.
- busy  out  1  transaction in progress.
- activate  in  1  request; level-sampled while idle.
- in_cs  in  NUM_SELECTS  active-high mask of chips to select.
- out_data  in  [OUT_BYTES][8]  bytes to send; index 0 is sent first.
- out_count  in  clog2(OUT_BYTES+1)  number of bytes to send.
- in_data  out  [IN_BYTES][8]  received bytes; index 0 is received first.
- in_count  in  clog2(IN_BYTES+1)  number of bytes to receive.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high.
- Reset values: cs all 1, sck 1, dio_e 0, dio_o 0, busy 0, in_data all 0, FSM in IDLE. Reset aborts any transaction in progress within the same cycle.
- IDLE: if activate=1, capture out_data, out_count, in_count and in_cs. busy=1 from the next cycle. activate while busy is ignored.
- Handshake: activate is level-sensitive. If activate is still high when the block returns to IDLE, a new transaction starts. The caller drops activate after it sees busy.
- Count limits: counts above OUT_BYTES / IN_BYTES are clamped to the maximum. If both counts are 0, the block still runs a CS-only frame (no SCK edges).
- CS_SETUP: cs = ~in_cs. Hold for one half period with sck high.
- WRITE: for each output bit, with dio_e=1:
  - sck goes low and dio_o takes the bit;
  - hold for a half period;
  - sck goes high and is held for a half period.
  - Byte and bit order are set by LSB_FIRST.
- READ: dio_e=0 for the whole phase. For each input bit:
  - sck is low for a half period;
  - sck goes high and dio_i is sampled on that cycle;
  - sck is held high for a half period.
  - Bits are assembled into in_data[k] per LSB_FIRST.
  - in_data bytes beyond in_count keep their previous values.
- HOLD: sck high, dio_e=0, cs still asserted, for ALL_DONE_DELAY × CLK_DIV cycles.
- CS_HIGH: all cs deasserted. Wait one half period, then return to IDLE with busy=0.
- dio_e is 0 whenever the block is not in WRITE.
- SCK timing: exactly CLK_DIV/2 clk per level. Generated from a down-counter reloaded at every phase edge.

Decomposition:
- Package spi3w_pkg: state enum (IDLE, CS_SETUP, WRITE, READ, HOLD, CS_HIGH) and the width helper constants.
- One natural sub-module, spi_half_tick: half-period counter that emits a tick every CLK_DIV/2 cycles; it is cleared on phase start.

Test Plan:
- One write, LSB first: out_count=1, out_data[0]=8'h40, CLK_DIV=20.
  - Exactly 8 rising sck edges, 20 clk apart.
  - dio_o at the rising edges reads 0,0,0,0,0,0,1,0.
  - cs low around the whole burst; busy high from activate+1 until cs is back high plus 10 cycles.
- Five-byte write: C0, 01, 02, 04, 08.
  - 40 sck edges; byte order 0→4.
  - dio_e=1 throughout the write phase; cs never toggles mid-frame.
- Read: out_count=1 (8'h42), in_count=4, dio_i driven with the pattern A5,3C,FF,00.
  - dio_e drops after the 8th bit.
  - in_data = {A5,3C,FF,00} after busy falls.
- Handshake:
  - activate held high for 3 cycles → exactly one transaction.
  - activate held high through completion → a second transaction starts immediately.
  - activate pulsed while busy → ignored.
- Reset mid-WRITE (after 3 bits) → next cycle: cs=1, sck=1, dio_e=0, busy=0. A fresh transaction afterwards completes correctly.
- LSB_FIRST=0 with out_data[0]=8'h80 → first bit sampled is 1, the rest are 0. Counts of 0/0 → a cs pulse with no sck edges.
